// File: rtl/cpu_nios_relay_pkg.sv
// Shared register map, FSM state type and status bit position for the relay output port.
package cpu_nios_relay_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_PULSE  = 2'd1;
  localparam logic [1:0] REG_PLEN   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int STATUS_BUSY_BIT = 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } relay_state_t;

endpackage

// File: rtl/cpu_nios_pulse_timer.sv
// One-shot pulse FSM and down-counter; trigger (re)loads max(len,1) and wins over expiry.
// o_expire flags the last active cycle of a pulse that is not being retriggered.
module cpu_nios_pulse_timer
  import cpu_nios_relay_pkg::*;
#(
  parameter int LEN_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_trigger,
  input  logic                 i_abort,
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic                 o_busy,
  output logic                 o_expire
);

  relay_state_t         r_state;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [LEN_WIDTH-1:0] w_load;
  logic                 w_last;

  // A programmed length of zero still produces a single-cycle pulse.
  assign w_load   = (i_len == '0) ? LEN_WIDTH'(1) : i_len;
  assign w_last   = (r_cnt == LEN_WIDTH'(1));
  assign o_busy   = (r_state == ST_PULSE);
  assign o_expire = o_busy && w_last && !i_trigger;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (i_trigger) begin
      r_state <= ST_PULSE;
      r_cnt   <= w_load;
    end else if (r_state == ST_PULSE) begin
      if (i_abort || w_last) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_nios_relay_out.sv
// Avalon-MM relay/LED output port: DATA register OR'd with hardware-timed pulse bits.
// Register file, pulse-bit accumulation, registered read mux (latency 1) and out_port register.
module cpu_nios_relay_out
  import cpu_nios_relay_pkg::*;
#(
  parameter int          WIDTH       = 10,
  parameter int          LEN_WIDTH   = 24,
  parameter logic [31:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]     r_data;
  logic [WIDTH-1:0]     r_pulse_bits;
  logic [WIDTH-1:0]     r_out;
  logic [LEN_WIDTH-1:0] r_plen;
  logic [31:0]          r_readdata;

  logic                 w_wr;
  logic                 w_trigger;
  logic                 w_abort;
  logic                 w_busy;
  logic                 w_expire;
  logic                 w_busy_nxt;
  logic [WIDTH-1:0]     w_mask;
  logic [WIDTH-1:0]     w_data_nxt;
  logic [WIDTH-1:0]     w_pulse_nxt;
  logic [LEN_WIDTH-1:0] w_plen_nxt;
  logic [31:0]          w_rd_nxt;
  logic                 w_unused;

  assign w_wr      = chipselect && !write_n;
  assign w_mask    = writedata[WIDTH-1:0];
  assign w_trigger = w_wr && (address == REG_PULSE) && (w_mask != '0);
  assign w_abort   = w_wr && (address == REG_STATUS) && writedata[STATUS_BUSY_BIT];
  assign w_unused  = ^writedata;

  cpu_nios_pulse_timer #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_trigger(w_trigger),
    .i_abort  (w_abort),
    .i_len    (r_plen),
    .o_busy   (w_busy),
    .o_expire (w_expire)
  );

  // Next-state values feed both the registers and the read mux so reads are post-update.
  always_comb begin
    w_data_nxt  = r_data;
    w_plen_nxt  = r_plen;
    w_pulse_nxt = r_pulse_bits;
    if (w_wr && (address == REG_DATA)) w_data_nxt = writedata[WIDTH-1:0];
    if (w_wr && (address == REG_PLEN)) w_plen_nxt = writedata[LEN_WIDTH-1:0];
    if (w_trigger) begin
      w_pulse_nxt = r_pulse_bits | w_mask;
    end else if (w_expire || w_abort) begin
      w_pulse_nxt = '0;
    end
    w_busy_nxt = w_trigger || (w_busy && !w_abort && !w_expire);
  end

  always_comb begin
    w_rd_nxt = '0;
    case (address)
      REG_DATA:  w_rd_nxt = 32'(w_data_nxt);
      REG_PULSE: w_rd_nxt = 32'(w_pulse_nxt);
      REG_PLEN:  w_rd_nxt = 32'(w_plen_nxt);
      default:   w_rd_nxt[STATUS_BUSY_BIT] = w_busy_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data       <= RESET_VALUE[WIDTH-1:0];
      r_plen       <= '0;
      r_pulse_bits <= '0;
      r_out        <= RESET_VALUE[WIDTH-1:0];
      r_readdata   <= '0;
    end else begin
      r_data       <= w_data_nxt;
      r_plen       <= w_plen_nxt;
      r_pulse_bits <= w_pulse_nxt;
      r_out        <= w_data_nxt | w_pulse_nxt;
      r_readdata   <= w_rd_nxt;
    end
  end

  assign out_port = r_out;
  assign readdata = r_readdata;

endmodule

// File: tb/tb_cpu_nios_relay_out.sv
// Bench for cpu_nios_relay_out: pulse-window model checked every cycle plus directed literal checks.
module tb_cpu_nios_relay_out;

  localparam int          WIDTH     = 10;
  localparam int          LEN_WIDTH = 24;
  localparam logic [31:0] RV        = 32'h0000_00A2;
  localparam logic [31:0] WMASK     = 32'h0000_03FF;
  localparam logic [31:0] LMASK     = 32'h00FF_FFFF;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b0;
  logic [1:0]       address    = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n    = 1'b1;
  logic [31:0]      writedata  = 32'd0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_nios_relay_out #(
    .WIDTH      (WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .RESET_VALUE(RV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a pulse is a set of bits active for every cycle index below m_end.
  longint      now, m_end;
  logic [31:0] m_data, m_plen, m_mask, m_rd;

  always @(posedge clk or negedge reset_n) begin : model
    longint      t, e;
    logic [31:0] d, p, m, rd;
    logic        busy;
    if (!reset_n) begin
      now    <= 0;
      m_end  <= 0;
      m_data <= RV & WMASK;
      m_plen <= 0;
      m_mask <= 0;
      m_rd   <= 0;
    end else begin
      t = now + 1;
      e = m_end;
      d = m_data;
      p = m_plen;
      m = m_mask;
      busy = (t - 1) < e;
      if (chipselect && !write_n) begin
        case (address)
          2'd0: d = writedata & WMASK;
          2'd1: if ((writedata & WMASK) != 0) begin
                  m = (busy ? m : 32'd0) | (writedata & WMASK);
                  e = t + ((p == 0) ? 64'd1 : longint'(p));
                end
          2'd2: p = writedata & LMASK;
          default: if (writedata[0] && busy) e = t;
        endcase
      end
      busy = t < e;
      if (!busy) m = 0;
      case (address)
        2'd0:    rd = d;
        2'd1:    rd = m;
        2'd2:    rd = p;
        default: rd = {31'd0, busy};
      endcase
      now    <= t;
      m_end  <= e;
      m_data <= d;
      m_plen <= p;
      m_mask <= m;
      m_rd   <= rd;
    end
  end

  always @(negedge clk) begin
    chk("model_out_port", 32'(out_port), m_data | m_mask);
    chk("model_readdata", readdata, m_rd);
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    @(negedge clk);
    v = readdata;
  endtask

  // Counts cycles out_port[b0]/[b1] are high over n cycles; optionally injects one write at cycle inj.
  task automatic window(input int n, input int inj, input logic [1:0] ia, input logic [31:0] id,
                        input int b0, input int b1, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < n; i++) begin
      if (out_port[b0]) c0++;
      if (out_port[b1]) c1++;
      if (i == inj) begin
        address    = ia;
        writedata  = id;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end else begin
        chipselect = 1'b0;
        write_n    = 1'b1;
      end
      @(negedge clk);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    int          c0, c1, c2, c3;
    logic [31:0] v;

    repeat (2) @(negedge clk);
    chk("reset_out_port", 32'(out_port), 32'h0A2);
    chk("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    wr(2'd0, 32'h2A5);
    chk("data_out_port", 32'(out_port), 32'h2A5);
    rd(2'd0, v);
    chk("data_readback", v, 32'h0000_02A5);
    wr(2'd0, 32'h0);

    wr(2'd2, 32'd5);
    wr(2'd1, 32'h004);
    address = 2'd3;
    window(3, -1, 2'd0, 32'd0, 2, 2, c0, c1);
    chk("plen5_busy_mid", {31'd0, readdata[0]}, 32'd1);
    window(9, -1, 2'd0, 32'd0, 2, 2, c2, c3);
    chk("plen5_bit2_cycles", 32'(c0 + c2), 32'd5);
    chk("plen5_busy_after", readdata, 32'd0);

    wr(2'd2, 32'd0);
    wr(2'd1, 32'h004);
    window(6, -1, 2'd0, 32'd0, 2, 2, c0, c1);
    chk("plen0_bit2_cycles", 32'(c0), 32'd1);

    wr(2'd2, 32'd8);
    wr(2'd1, 32'h001);
    window(16, 2, 2'd1, 32'h002, 0, 1, c0, c1);
    chk("retrig_bit0_cycles", 32'(c0), 32'd11);
    chk("retrig_bit1_cycles", 32'(c1), 32'd8);

    wr(2'd2, 32'd3);
    wr(2'd1, 32'h001);
    window(10, 2, 2'd1, 32'h004, 0, 2, c0, c1);
    chk("expiry_retrig_bit0", 32'(c0), 32'd6);
    chk("expiry_retrig_bit2", 32'(c1), 32'd3);

    wr(2'd0, 32'h100);
    wr(2'd2, 32'd50);
    wr(2'd1, 32'h300);
    window(10, 3, 2'd3, 32'h1, 9, 8, c0, c1);
    chk("abort_bit9_cycles", 32'(c0), 32'd4);
    chk("abort_bit8_cycles", 32'(c1), 32'd10);
    rd(2'd3, v);
    chk("abort_busy", v, 32'd0);
    wr(2'd3, 32'h1);
    rd(2'd0, v);
    chk("abort_idle_noop_data", v, 32'h100);
    wr(2'd0, 32'h0);

    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, v);
    chk("mask_data", v, 32'h0000_03FF);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, v);
    chk("mask_plen", v, 32'h00FF_FFFF);
    wr(2'd0, 32'h0);
    wr(2'd2, 32'd2);
    wr(2'd1, 32'h0);
    rd(2'd3, v);
    chk("pulse_zero_idle", v, 32'd0);
    wr(2'd1, 32'hFFFF_FC00);
    rd(2'd3, v);
    chk("pulse_high_bits_idle", v, 32'd0);

    wr(2'd2, 32'd100);
    wr(2'd1, 32'h001);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_out_port", 32'(out_port), 32'h0A2);
    chk("midreset_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    window(10, -1, 2'd0, 32'd0, 0, 1, c0, c1);
    chk("postreset_bit0", 32'(c0), 32'd0);
    rd(2'd3, v);
    chk("postreset_busy", v, 32'd0);
    rd(2'd2, v);
    chk("postreset_plen", v, 32'd0);
    rd(2'd0, v);
    chk("postreset_data", v, 32'h0A2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
